// File: rtl/keypad_entry_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry_ctrl_pkg
// Description : Shared encodings for the keypad entry controller: shift array
//               mode codes, controller states, field widths and a key
//               qualification helper.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_entry_ctrl_pkg;

  localparam int CODE_W = 4;  // BCD digit width
  localparam int CNT_W  = 3;  // digit count width (0..4)
  localparam int MODE_W = 2;  // shift array mode width

  // Shift register array mode encodings
  typedef enum logic [MODE_W-1:0] {
    SR_HOLD  = 2'b00,
    SR_SHIFT = 2'b01,
    SR_CLR   = 2'b10,
    SR_LOAD  = 2'b11
  } sr_mode_e;

  // Controller state encodings
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_COMMIT   = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_READY    = 3'd4
  } state_e;

  // A key only counts as pressed when the encoder reports a real BCD digit.
  function automatic logic is_digit(input logic valid, input logic [CODE_W-1:0] code);
    return valid && (code <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_entry_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry_ctrl_if
// Description : Bundle of encoder/command inputs and shift array/status
//               outputs of the keypad entry controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_entry_ctrl_if;
  import keypad_entry_ctrl_pkg::*;

  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              enter;
  logic              clear;
  logic [MODE_W-1:0] sr_mode;
  logic [CODE_W-1:0] sr_din;
  logic [CNT_W-1:0]  digit_cnt;
  logic              code_ready;
  logic              entry_err;

  // Side that supplies keys/commands and observes the controller
  modport master (
    output key_valid, key_code, enter, clear,
    input  sr_mode, sr_din, digit_cnt, code_ready, entry_err
  );

  // The controller itself
  modport slave (
    input  key_valid, key_code, enter, clear,
    output sr_mode, sr_din, digit_cnt, code_ready, entry_err
  );
endinterface
`default_nettype wire

// File: rtl/keypad_entry_ctrl_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer
// Description : Stable-count debouncer for key presses and releases. Counts
//               consecutive samples of an unchanged valid code (press) or of
//               no valid key (release) and strobes accept/released on the
//               DEB_CYCLES-th sample.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debouncer
  import keypad_entry_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              key_ok,      // qualified key_valid
  input  wire logic [CODE_W-1:0] key_code,
  input  wire logic              press_en,    // count press samples
  input  wire logic              release_en,  // count release samples
  input  wire logic              freeze,      // hold count this cycle
  output logic                   accept,
  output logic                   released,
  output logic [CODE_W-1:0]      code
);

  localparam logic [4:0] DEB_TARGET = 5'(DEB_CYCLES);

  logic [3:0]        r_cnt;
  logic [CODE_W-1:0] r_code;
  logic [3:0]        w_cnt_d;
  logic [CODE_W-1:0] w_code_d;
  logic [4:0]        w_cnt_inc;

  assign w_cnt_inc = {1'b0, r_cnt} + 5'd1;

  // Next count, relatch and strobes; with no enable the count is flushed.
  always_comb begin
    w_cnt_d  = r_cnt;
    w_code_d = r_code;
    accept   = 1'b0;
    released = 1'b0;
    code     = r_code;
    if (freeze) begin
      w_cnt_d = r_cnt;
    end else if (press_en) begin
      if (!key_ok) begin
        w_cnt_d = 4'd0;
      end else if ((r_cnt == 4'd0) || (key_code != r_code)) begin
        // First sample of a new or changed code counts as sample one
        w_code_d = key_code;
        code     = key_code;
        if (DEB_TARGET == 5'd1) begin
          accept  = 1'b1;
          w_cnt_d = 4'd0;
        end else begin
          w_cnt_d = 4'd1;
        end
      end else if (w_cnt_inc == DEB_TARGET) begin
        accept  = 1'b1;
        w_cnt_d = 4'd0;
      end else begin
        w_cnt_d = w_cnt_inc[3:0];
      end
    end else if (release_en) begin
      if (key_ok) begin
        w_cnt_d = 4'd0;
      end else if (w_cnt_inc == DEB_TARGET) begin
        released = 1'b1;
        w_cnt_d  = 4'd0;
      end else begin
        w_cnt_d = w_cnt_inc[3:0];
      end
    end else begin
      w_cnt_d = 4'd0;
    end
  end

  // Count and latched code registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 4'd0;
      r_code <= '0;
    end else begin
      r_cnt  <= w_cnt_d;
      r_code <= w_code_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry_ctrl
// Description : Keypad entry sequencer. Debounces BCD key events, commits
//               each accepted digit as one shift-in command to the four-digit
//               shift array, tracks the digit count and handles enter/clear,
//               pulsing code_ready or entry_err.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry_ctrl
  import keypad_entry_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int MAX_DIGITS = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_ui,
  keypad_entry_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_DIGITS);

  state_e            r_state, w_state_d;
  sr_mode_e          r_sr_mode, w_sr_mode_d;
  logic [CODE_W-1:0] r_sr_din, w_sr_din_d;
  logic [CNT_W-1:0]  r_digit_cnt, w_digit_cnt_d;
  logic              r_code_ready, w_code_ready_d;
  logic              r_entry_err, w_entry_err_d;

  logic              w_key_ok;
  logic              w_press_en;
  logic              w_release_en;
  logic              w_freeze;
  logic              w_accept;
  logic              w_released;
  logic [CODE_W-1:0] w_code;

  assign w_key_ok = is_digit(bus.key_valid, bus.key_code);

  // Debouncer enables come straight from state and commands so the accept
  // strobe never feeds back into its own enable.
  always_comb begin
    w_press_en   = 1'b0;
    w_release_en = 1'b0;
    w_freeze     = 1'b0;
    if (!bus.clear) begin
      w_press_en   = ((r_state == ST_IDLE) && !bus.enter) || (r_state == ST_DEBOUNCE);
      w_release_en = (r_state == ST_RELEASE) && !bus.enter;
      // A rejected enter in RELEASE keeps the release count where it was
      w_freeze     = (r_state == ST_RELEASE) && bus.enter && (r_digit_cnt != FULL_CNT);
    end
  end

  key_debouncer #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debouncer (
    .clk        (clk),
    .rst        (rst_ui),
    .key_ok     (w_key_ok),
    .key_code   (bus.key_code),
    .press_en   (w_press_en),
    .release_en (w_release_en),
    .freeze     (w_freeze),
    .accept     (w_accept),
    .released   (w_released),
    .code       (w_code)
  );

  // Next state and next registered outputs; clear beats enter beats keys.
  always_comb begin
    w_state_d      = r_state;
    w_sr_mode_d    = SR_HOLD;
    w_sr_din_d     = r_sr_din;
    w_digit_cnt_d  = r_digit_cnt;
    w_code_ready_d = 1'b0;
    w_entry_err_d  = 1'b0;
    if (bus.clear) begin
      w_sr_mode_d   = SR_CLR;
      w_digit_cnt_d = '0;
      w_state_d     = ST_RELEASE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.enter) begin
            if (r_digit_cnt == FULL_CNT) begin
              w_code_ready_d = 1'b1;
              w_state_d      = ST_READY;
            end else begin
              w_entry_err_d = 1'b1;
            end
          end else if (w_key_ok) begin
            w_state_d = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (!w_key_ok) begin
            w_state_d = ST_IDLE;
          end
        end
        ST_COMMIT: begin
          w_state_d = ST_RELEASE;
        end
        ST_RELEASE: begin
          if (bus.enter) begin
            if (r_digit_cnt == FULL_CNT) begin
              w_code_ready_d = 1'b1;
              w_state_d      = ST_READY;
            end else begin
              w_entry_err_d = 1'b1;
            end
          end else if (w_released) begin
            w_state_d = ST_IDLE;
          end
        end
        ST_READY: begin
          w_state_d = ST_READY;
        end
        default: begin
          w_state_d = ST_IDLE;
        end
      endcase

      // Accept only fires while pressing is enabled (IDLE/DEBOUNCE); the
      // commit action is registered so it is visible during COMMIT.
      if (w_accept) begin
        w_state_d = ST_COMMIT;
        if (r_digit_cnt < FULL_CNT) begin
          w_sr_mode_d   = SR_SHIFT;
          w_sr_din_d    = w_code;
          w_digit_cnt_d = r_digit_cnt + 3'd1;
        end else begin
          w_entry_err_d = 1'b1;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst_ui) begin
      r_state      <= ST_IDLE;
      r_sr_mode    <= SR_HOLD;
      r_sr_din     <= '0;
      r_digit_cnt  <= '0;
      r_code_ready <= 1'b0;
      r_entry_err  <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_sr_mode    <= w_sr_mode_d;
      r_sr_din     <= w_sr_din_d;
      r_digit_cnt  <= w_digit_cnt_d;
      r_code_ready <= w_code_ready_d;
      r_entry_err  <= w_entry_err_d;
    end
  end

  assign bus.sr_mode    = r_sr_mode;
  assign bus.sr_din     = r_sr_din;
  assign bus.digit_cnt  = r_digit_cnt;
  assign bus.code_ready = r_code_ready;
  assign bus.entry_err  = r_entry_err;

endmodule
`default_nettype wire

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Sequencing controller between the keypad input encoder and the four-digit shift register array. It debounces each BCD key event and commits each accepted digit as exactly one shift-in command. It tracks how many digits are held and handles enter/clear commands, flagging a complete four-digit code or an entry error. It is the only driver of the shift register array's mode and data inputs.

## Interface
Parameters:
- DEB_CYCLES, 4: consecutive stable cycles required to accept a press or a release; legal range 1..15.
- MAX_DIGITS, 4: digit capacity of the shift register array; fixed at 4 in this design.

Ports:
- clk  input  1  system clock, single clock domain.
- rst_ui  input  1  synchronous, active-high reset.
- key_valid  input  1  encoder valid flag (encoder out[4]).
- key_code  input  4  encoder BCD digit (encoder out[3:0]).
- enter  input  1  enter command, level-sampled each cycle.
- clear  input  1  clear command, level-sampled each cycle.
- sr_mode  output  2  shift array mode: 00 hold, 01 shift-in, 10 clear, 11 parallel load (never driven by this block).
- sr_din  output  4  digit presented to the array, valid when sr_mode=01.
- digit_cnt  output  3  digits currently stored, 0..4.
- code_ready  output  1  one-cycle pulse: a four-digit code has been entered.
- entry_err  output  1  one-cycle pulse: overflow digit, or enter with fewer than 4 digits.

## Operation
- Reset (rst_ui=1 at a clk edge): state IDLE; sr_mode=00, sr_din=0, digit_cnt=0, code_ready=0, entry_err=0; debounce counter 0. Reset mid-operation aborts immediately with no pending pulse.
- key_valid=1 with key_code>9 is treated as key_valid=0.
- States:
  - IDLE: key_valid=1 → DEBOUNCE; latch code; deb=1.
  - DEBOUNCE:
    - Same code held: deb increments.
    - At the DEB_CYCLES-th consecutive sample → COMMIT.
    - Code changes while valid: relatch the code, deb=1.
    - key_valid=0 → IDLE.
  - COMMIT (1 cycle):
    - digit_cnt<4: sr_mode=01, sr_din=latched code, digit_cnt+1.
    - digit_cnt=4: sr_mode=00, entry_err pulse, count unchanged.
    - Then → RELEASE.
  - RELEASE: requires DEB_CYCLES consecutive cycles of key_valid=0, then → IDLE. Any key_valid=1 resets the release count.
  - READY: sr_mode=00; keys ignored; only clear exits.
- enter, evaluated in IDLE or RELEASE:
  - digit_cnt=4: code_ready pulse, → READY.
  - Otherwise: entry_err pulse, state unchanged.
  - Ignored in DEBOUNCE and COMMIT.
- clear, any state: sr_mode=10 for one cycle, digit_cnt=0, → RELEASE, so a held key is not re-registered.
- Priority within a cycle: rst_ui > clear > enter > key activity.
- The array holds the most recent digit in register 1; older digits move toward register 4.

## Timing
- All outputs are registered.
- A press produces sr_mode=01 for exactly one cycle, following the DEB_CYCLES-th consecutive rising edge at which key_valid=1 with an unchanged code.
- A press shorter than DEB_CYCLES cycles produces nothing.
- A held key produces exactly one shift, regardless of duration.
- Minimum spacing between two accepted digits is 2·DEB_CYCLES+1 cycles.
- code_ready and entry_err appear the cycle after the qualifying enter sample. Each is exactly one cycle wide; they are never asserted together.
- With DEB_CYCLES=1: a press is accepted on its first sample, and release needs one low cycle.

## Structure
- Shared constants file (alongside the existing library): sr_mode encodings (HOLD, SHIFT, CLR, LOAD) and state encodings.
- One sub-module, key_debouncer:
  - Stable-count, relatch and release-count logic, parameterised by DEB_CYCLES.
  - Outputs accept and released strobes plus the latched code.
- The top level holds the FSM, digit counter and output registers.

## Test plan
- Reset, then keys 2,1,9,7, each held 5 cycles with 5 idle cycles between (DEB_CYCLES=4) → four single-cycle sr_mode=01 with sr_din 2,1,9,7; digit_cnt 1→4; enter → code_ready one cycle, state READY.
- 3-cycle press of key 5 → no sr_mode change, digit_cnt stays 0. A 40-cycle hold of key 5 → exactly one shift.
- Fifth key after 4 digits → entry_err one cycle, sr_mode stays 00, digit_cnt=4. Enter with 2 digits → entry_err, no code_ready.
- clear while key 8 is held, with digit_cnt=3 → sr_mode=10 for one cycle, digit_cnt=0. No shift until key 8 is released for 4 cycles and pressed again.
- Key code changes 3→6 mid-debounce → single shift with sr_din=6, 4 cycles after the change.
- rst_ui asserted during COMMIT and during READY → next cycle all outputs 0, state IDLE; a following 4-digit entry works normally.
